// File: rtl/spi_frame_tx.sv
// Buffered mode-0 SPI master transmitter for the DAC link.
// Sends one CSn-framed, MSB-first word per accepted write and holds one further word while a frame shifts.
module spi_frame_tx #(
  parameter int WIDTH    = 16,
  parameter int CLKDIV   = 2,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1,
  parameter int CS_IDLE  = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic [WIDTH-1:0] tx,
  output logic             ready,
  output logic             running,
  output logic             done,
  output logic             overflow,
  output logic             SCL,
  output logic             MOSI,
  output logic             CSn
);

  localparam int MAX_AB = (CLKDIV > CS_SETUP) ? CLKDIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW     = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DESEL} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;

  logic             start_buf;
  logic             start_new;
  logic             load_buf;
  logic [WIDTH-1:0] start_word;

  assign ready = !buf_full;

  // A word buffered on the last DESEL edge is picked up from IDLE one cycle later.
  always_comb begin
    start_buf  = buf_full && ((state == IDLE) || ((state == DESEL) && (cnt == '0)));
    start_new  = we && !buf_full && (state == IDLE);
    load_buf   = we && !buf_full && (state != IDLE);
    start_word = start_buf ? buf_q : tx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      SCL      <= 1'b0;
      MOSI     <= 1'b0;
      CSn      <= 1'b1;
      running  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= we && buf_full;

      if (load_buf) begin
        buf_q    <= tx;
        buf_full <= 1'b1;
      end else if (start_buf) begin
        buf_full <= 1'b0;
      end

      if (start_buf || start_new) begin
        state   <= SETUP;
        shreg   <= start_word[WIDTH-2:0];
        MOSI    <= start_word[WIDTH-1];
        CSn     <= 1'b0;
        SCL     <= 1'b0;
        running <= 1'b1;
        cnt     <= CW'(CS_SETUP - 1);
      end else begin
        case (state)
          IDLE: ;
          SETUP: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state   <= SHIFT;
              SCL     <= 1'b1;
              cnt     <= CW'(CLKDIV - 1);
              bit_cnt <= BW'(WIDTH - 1);
            end
          end
          SHIFT: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (SCL) begin
              SCL <= 1'b0;
              cnt <= CW'(CLKDIV - 1);
              // Next bit goes out on the falling edge; the LSB is held after the last fall.
              if (bit_cnt != '0) begin
                MOSI  <= shreg[WIDTH-2];
                shreg <= shreg << 1;
              end
            end else if (bit_cnt == '0) begin
              state <= HOLD;
              cnt   <= CW'(CS_HOLD - 1);
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
              SCL     <= 1'b1;
              cnt     <= CW'(CLKDIV - 1);
            end
          end
          HOLD: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state <= DESEL;
              CSn   <= 1'b1;
              done  <= 1'b1;
              cnt   <= CW'(CS_IDLE - 1);
            end
          end
          DESEL: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
